// File: rtl/bottleneck_narrower_pkg.sv
// bottleneck_pkg: shared definitions for the bottleneck narrower.
//   siz_e      - access size encoding (log2 of the access byte count).
//   beats_for  - number of slave beats one master access needs.
//   lane_mask  - address offset bits that must be zero for a naturally
//                aligned access of the given size.
`timescale 1ns/1ps
package bottleneck_pkg;

    typedef enum logic [1:0] {
        SIZ_BYTE  = 2'd0,
        SIZ_HALF  = 2'd1,
        SIZ_WORD  = 2'd2,
        SIZ_DWORD = 2'd3
    } siz_e;

    // An access narrower than the slave port still costs one beat.
    function automatic int beats_for(input logic [1:0] siz, input int slave_w);
        int bytes;
        int sb;
        bytes = 1 << siz;
        sb    = slave_w / 8;
        return (bytes > sb) ? bytes / sb : 1;
    endfunction

    // Offset bits within an access of this size: 0, 1, 3 or 7.
    function automatic logic [2:0] lane_mask(input logic [1:0] siz);
        return 3'((4'd1 << siz) - 4'd1);
    endfunction

endpackage

// File: rtl/bottleneck_narrower_if.sv
// bottleneck_narrower_if: master-side and slave-side signals of the narrower.
//   bridge - the narrower itself (takes M*I / S*I, drives M*O / S*O).
//   master - the core side that issues accesses.
//   slave  - the narrow bus side that answers beats.
// Handshake: a master access is offered while MCycI & MStbI are high and is
// held stable until MAckO or MErrO; a slave beat is offered while SStbO is
// high and completes in the cycle SAckI or SErrI is sampled high.
// dbgBeat / dbgBusy expose the internal beat counter and busy flag.
`timescale 1ns/1ps
interface bottleneck_narrower_if #(
    parameter int ADDR_W   = 64,
    parameter int MASTER_W = 64,
    parameter int SLAVE_W  = 16
);
    localparam int MAX_NB = MASTER_W / SLAVE_W;
    localparam int BEAT_W = (MAX_NB > 1) ? $clog2(MAX_NB) : 1;

    logic [ADDR_W-1:0]   MAdrI;
    logic [MASTER_W-1:0] MDatI;
    logic [1:0]          MSizI;
    logic                MSignedI;
    logic                MWeI;
    logic                MCycI;
    logic                MStbI;
    logic                MAckO;
    logic                MErrAlignO;
    logic                MErrO;
    logic [MASTER_W-1:0] MDatO;

    logic [ADDR_W-1:0]   SAdrO;
    logic [SLAVE_W-1:0]  SDatO;
    logic [1:0]          SSizO;
    logic                SSignedO;
    logic                SWeO;
    logic                SCycO;
    logic                SStbO;
    logic                SAckI;
    logic                SErrI;
    logic [SLAVE_W-1:0]  SDatI;

    logic [BEAT_W-1:0]   dbgBeat;
    logic                dbgBusy;

    modport bridge (
        input  MAdrI, MDatI, MSizI, MSignedI, MWeI, MCycI, MStbI,
        output MAckO, MErrAlignO, MErrO, MDatO,
        output SAdrO, SDatO, SSizO, SSignedO, SWeO, SCycO, SStbO,
        input  SAckI, SErrI, SDatI,
        output dbgBeat, dbgBusy
    );

    modport master (
        output MAdrI, MDatI, MSizI, MSignedI, MWeI, MCycI, MStbI,
        input  MAckO, MErrAlignO, MErrO, MDatO
    );

    modport slave (
        input  SAdrO, SDatO, SSizO, SSignedO, SWeO, SCycO, SStbO,
        output SAckI, SErrI, SDatI
    );

endinterface

// File: rtl/bottleneck_narrower_beat_ctr.sv
// bottleneck_beat_ctr: beat index and busy flag for one master access.
//   clk_i, reset_ni - clock, asynchronous active-low reset
//   stb             - slave strobe currently offered
//   ack, err        - slave beat acknowledge / error
//   lastBeat        - index of the final beat of the current access
//   beat            - registered index of the beat being offered
//   isFinal         - current beat is the final one
//   busy            - an access is partway through its beats
`timescale 1ns/1ps
module bottleneck_beat_ctr #(
    parameter  int MAX_NB = 4,
    localparam int BEAT_W = (MAX_NB > 1) ? $clog2(MAX_NB) : 1
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              stb,
    input  logic              ack,
    input  logic              err,
    input  logic [BEAT_W-1:0] lastBeat,
    output logic [BEAT_W-1:0] beat,
    output logic              isFinal,
    output logic              busy
);

    assign isFinal = (beat == lastBeat);

    // Any cycle without a strobe (drop, misalignment) forgets the burst, so
    // the next access always starts at beat 0.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            beat <= '0;
            busy <= 1'b0;
        end else if (!stb || err || (ack && isFinal)) begin
            beat <= '0;
            busy <= 1'b0;
        end else begin
            busy <= 1'b1;
            if (ack) begin
                beat <= beat + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bottleneck_narrower.sv
// bottleneck_narrower: splits one master access (1/2/4/8 bytes) into
// naturally aligned beats on a narrower slave port.
//   clk_i, reset_ni - clock, asynchronous active-low reset
//   bus (bridge)    - master request/response, slave beat signals, debug
// Read data of earlier beats is parked in a hold register; the final beat's
// data is forwarded live so MAckO lands in the same cycle as the last SAckI.
`timescale 1ns/1ps
module bottleneck_narrower
    import bottleneck_pkg::*;
#(
    parameter int MASTER_W = 64,
    parameter int SLAVE_W  = 16,
    parameter int ADDR_W   = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    bottleneck_narrower_if.bridge bus
);

    localparam int SB     = SLAVE_W / 8;
    localparam int SLG    = $clog2(SB);
    localparam int MAX_NB = MASTER_W / SLAVE_W;
    localparam int BEAT_W = (MAX_NB > 1) ? $clog2(MAX_NB) : 1;

    if (SLAVE_W > MASTER_W || MASTER_W < 16 || MASTER_W > 64 || SLAVE_W < 8 ||
        (MASTER_W & (MASTER_W - 1)) != 0 || (SLAVE_W & (SLAVE_W - 1)) != 0)
    begin : g_param_check
        $error("bottleneck_narrower: unsupported MASTER_W=%0d SLAVE_W=%0d",
               MASTER_W, SLAVE_W);
    end

    logic                             req;
    logic                             sizeBad;
    logic                             misalign;
    logic                             alignErr;
    logic                             stb;
    logic                             mAck;
    logic [1:0]                       slvSiz;
    logic [BEAT_W-1:0]                beat;
    logic [BEAT_W-1:0]                lastBeat;
    logic                             isFinal;
    logic                             busy;
    logic [MAX_NB-1:0][SLAVE_W-1:0]   wrLanes;
    logic [MAX_NB-1:0][SLAVE_W-1:0]   hold;
    logic [MAX_NB-1:0][SLAVE_W-1:0]   rdData;

    assign req      = bus.MCycI & bus.MStbI;
    assign sizeBad  = (4'd1 << bus.MSizI) > 4'(MASTER_W / 8);
    assign misalign = |(bus.MAdrI[2:0] & lane_mask(bus.MSizI));
    assign alignErr = req & (sizeBad | misalign);
    assign stb      = req & ~alignErr & reset_ni;
    assign slvSiz   = 2'(SLG);

    // Truncation only matters for oversized accesses, which never strobe.
    assign lastBeat = BEAT_W'(beats_for(bus.MSizI, SLAVE_W) - 1);

    bottleneck_beat_ctr #(.MAX_NB(MAX_NB)) u_beatCtr (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .stb      (stb),
        .ack      (bus.SAckI),
        .err      (bus.SErrI),
        .lastBeat (lastBeat),
        .beat     (beat),
        .isFinal  (isFinal),
        .busy     (busy)
    );

    assign wrLanes = bus.MDatI;

    // Error wins over ack, so an erroring beat is never captured.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            hold <= '0;
        end else if (stb && bus.SAckI && !bus.SErrI && !isFinal) begin
            hold[beat] <= bus.SDatI;
        end
    end

    always_comb begin
        rdData           = hold;
        rdData[lastBeat] = bus.SDatI;
        if (lastBeat == '0) begin
            rdData = MASTER_W'(bus.SDatI);
        end
    end

    assign mAck = stb & bus.SAckI & ~bus.SErrI & isFinal;

    assign bus.MAckO      = mAck;
    assign bus.MErrO      = stb & bus.SErrI;
    assign bus.MErrAlignO = alignErr;
    assign bus.MDatO      = mAck ? rdData : hold;

    // Slave-side fields are zeroed whenever no beat is offered.
    assign bus.SStbO    = stb;
    assign bus.SCycO    = stb;
    assign bus.SWeO     = bus.MWeI & stb;
    assign bus.SAdrO    = stb ? bus.MAdrI + (ADDR_W'(beat) << SLG) : '0;
    assign bus.SDatO    = stb ? wrLanes[beat] : '0;
    assign bus.SSizO    = stb ? ((bus.MSizI < slvSiz) ? bus.MSizI : slvSiz) : 2'd0;
    assign bus.SSignedO = stb & bus.MSignedI & (bus.MSizI < slvSiz);

    assign bus.dbgBeat = beat;
    assign bus.dbgBusy = busy;

endmodule

// File: tb/tb_bottleneck_narrower.sv
// Bench for bottleneck_narrower: a 16-bit slave instance driven by directed
// accesses and checked through expected-beat and expected-response queues,
// plus 32-bit and 8-bit slave instances for beat counts and mid-burst reset.
`timescale 1ns/1ps
module tb_bottleneck_narrower;
    import bottleneck_pkg::*;

    localparam int BEAT_QW = 82;   // {adr[63:0], we, chkDat, dat[15:0]}
    localparam int RESP_QW = 129;  // {isErr, mask[63:0], dat[63:0]}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bottleneck_narrower_if #(.ADDR_W(64), .MASTER_W(64), .SLAVE_W(16)) bus16 ();
    bottleneck_narrower_if #(.ADDR_W(64), .MASTER_W(64), .SLAVE_W(32)) bus32 ();
    bottleneck_narrower_if #(.ADDR_W(64), .MASTER_W(64), .SLAVE_W(8))  bus8 ();

    bottleneck_narrower #(.MASTER_W(64), .SLAVE_W(16), .ADDR_W(64)) u16 (
        .clk_i(clk), .reset_ni(rst_n), .bus(bus16));
    bottleneck_narrower #(.MASTER_W(64), .SLAVE_W(32), .ADDR_W(64)) u32 (
        .clk_i(clk), .reset_ni(rst_n), .bus(bus32));
    bottleneck_narrower #(.MASTER_W(64), .SLAVE_W(8), .ADDR_W(64)) u8 (
        .clk_i(clk), .reset_ni(rst_n), .bus(bus8));

    int n_checks = 0;
    int n_fail   = 0;
    int we_cycles = 0;
    int u8_resp   = 0;

    logic [BEAT_QW-1:0] exp_beat_q[$];
    logic [RESP_QW-1:0] exp_resp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp_v);
        end
    endtask

    task automatic check_idle(input string tag, input logic stb, input logic cyc,
                              input logic we, input logic [63:0] adr, input logic [63:0] sdat,
                              input logic [1:0] siz, input logic sgn, input logic ack,
                              input logic err, input logic aerr, input logic [63:0] mdat,
                              input logic [7:0] beat);
        check({tag, "_SStbO"},      64'(stb),  64'd0);
        check({tag, "_SCycO"},      64'(cyc),  64'd0);
        check({tag, "_SWeO"},       64'(we),   64'd0);
        check({tag, "_SAdrO"},      adr,       64'd0);
        check({tag, "_SDatO"},      sdat,      64'd0);
        check({tag, "_SSizO"},      64'(siz),  64'd0);
        check({tag, "_SSignedO"},   64'(sgn),  64'd0);
        check({tag, "_MAckO"},      64'(ack),  64'd0);
        check({tag, "_MErrO"},      64'(err),  64'd0);
        check({tag, "_MErrAlignO"}, 64'(aerr), 64'd0);
        check({tag, "_MDatO"},      mdat,      64'd0);
        check({tag, "_beat"},       64'(beat), 64'd0);
    endtask

    task automatic idle_checks_all(input string tag);
        check_idle({tag, "16"}, bus16.SStbO, bus16.SCycO, bus16.SWeO, bus16.SAdrO,
                   64'(bus16.SDatO), bus16.SSizO, bus16.SSignedO, bus16.MAckO,
                   bus16.MErrO, bus16.MErrAlignO, bus16.MDatO, 8'(bus16.dbgBeat));
        check_idle({tag, "32"}, bus32.SStbO, bus32.SCycO, bus32.SWeO, bus32.SAdrO,
                   64'(bus32.SDatO), bus32.SSizO, bus32.SSignedO, bus32.MAckO,
                   bus32.MErrO, bus32.MErrAlignO, bus32.MDatO, 8'(bus32.dbgBeat));
        check_idle({tag, "8"}, bus8.SStbO, bus8.SCycO, bus8.SWeO, bus8.SAdrO,
                   64'(bus8.SDatO), bus8.SSizO, bus8.SSignedO, bus8.MAckO,
                   bus8.MErrO, bus8.MErrAlignO, bus8.MDatO, 8'(bus8.dbgBeat));
    endtask

    // ---------------- scoreboard push helpers ----------------
    task automatic exp_beat(input logic [63:0] a, input logic we, input logic chk,
                            input logic [15:0] d);
        exp_beat_q.push_back({a, we, chk, d});
    endtask

    task automatic exp_resp(input logic err, input logic [63:0] mask, input logic [63:0] d);
        exp_resp_q.push_back({err, mask, d});
    endtask

    // ---------------- monitor (16-bit instance) ----------------
    always @(negedge clk) begin : monitor
        logic [BEAT_QW-1:0] eb;
        logic [RESP_QW-1:0] er;
        if (rst_n) begin
            if (bus16.SWeO) we_cycles++;
            if (bus16.SStbO && (bus16.SAckI || bus16.SErrI)) begin
                if (exp_beat_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: actual beat at %h required none", bus16.SAdrO);
                end else begin
                    eb = exp_beat_q.pop_front();
                    check("beat_adr", bus16.SAdrO, eb[81:18]);
                    check("beat_we", 64'(bus16.SWeO), 64'(eb[17]));
                    if (eb[16]) check("beat_dat", 64'(bus16.SDatO), 64'(eb[15:0]));
                end
            end
            if (bus16.MAckO || bus16.MErrO) begin
                if (exp_resp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL resp_unexpected: actual ack=%0b err=%0b required none",
                             bus16.MAckO, bus16.MErrO);
                end else begin
                    er = exp_resp_q.pop_front();
                    check("resp_err", 64'(bus16.MErrO), 64'(er[128]));
                    check("resp_ack", 64'(bus16.MAckO), 64'(!er[128]));
                    if (!er[128]) check("resp_dat", bus16.MDatO & er[127:64], er[63:0] & er[127:64]);
                end
            end
        end
    end

    always @(negedge clk) begin : u8_counter
        if (bus8.MAckO || bus8.MErrO) u8_resp++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_req(input logic [63:0] a, input logic [1:0] siz, input logic we,
                         input logic sgn, input logic [63:0] d);
        bus16.MAdrI = a; bus16.MSizI = siz; bus16.MWeI = we;
        bus16.MSignedI = sgn; bus16.MDatI = d;
        bus16.MCycI = 1'b1; bus16.MStbI = 1'b1;
    endtask

    task automatic m_idle();
        bus16.MCycI = 1'b0; bus16.MStbI = 1'b0; bus16.MWeI = 1'b0;
        bus16.MAdrI = '0; bus16.MDatI = '0; bus16.MSizI = 2'd0; bus16.MSignedI = 1'b0;
    endtask

    // Answers n beats, each after `waits` idle cycles; beat err_beat errors.
    task automatic s_beats(input int n, input int waits, input int err_beat,
                           input logic [63:0] rd);
        for (int k = 0; k < n; k++) begin
            repeat (waits) tick();
            bus16.SAckI = (k != err_beat);
            bus16.SErrI = (k == err_beat);
            bus16.SDatI = rd[k*16 +: 16];
            tick();
            bus16.SAckI = 1'b0;
            bus16.SErrI = 1'b0;
            bus16.SDatI = '0;
            if (k == err_beat) break;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int we_before;
        int u8_snap;
        m_idle();
        bus16.SAckI = 0; bus16.SErrI = 0; bus16.SDatI = '0;
        bus32.MAdrI = '0; bus32.MDatI = '0; bus32.MSizI = 2'd0; bus32.MSignedI = 0;
        bus32.MWeI = 0; bus32.MCycI = 0; bus32.MStbI = 0;
        bus32.SAckI = 0; bus32.SErrI = 0; bus32.SDatI = '0;
        bus8.MAdrI = '0; bus8.MDatI = '0; bus8.MSizI = 2'd0; bus8.MSignedI = 0;
        bus8.MWeI = 0; bus8.MCycI = 0; bus8.MStbI = 0;
        bus8.SAckI = 0; bus8.SErrI = 0; bus8.SDatI = '0;
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        idle_checks_all("rst");
        tick();

        // 8B read, zero wait: 0x1000/02/04/06, data assembled on 4th ack.
        exp_beat(64'h1000, 0, 0, 16'h0); exp_beat(64'h1002, 0, 0, 16'h0);
        exp_beat(64'h1004, 0, 0, 16'h0); exp_beat(64'h1006, 0, 0, 16'h0);
        exp_resp(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h4444_3333_2222_1111);
        m_req(64'h1000, SIZ_DWORD, 0, 0, 64'h0);
        s_beats(4, 0, -1, 64'h4444_3333_2222_1111);
        m_idle();
        tick();

        // 8B write, one wait per beat: lanes low to high, 8 cycles of SWeO.
        exp_beat(64'h3000, 1, 1, 16'h0011); exp_beat(64'h3002, 1, 1, 16'hEEFF);
        exp_beat(64'h3004, 1, 1, 16'hCCDD); exp_beat(64'h3006, 1, 1, 16'hAABB);
        exp_resp(0, 64'h0, 64'h0);
        we_before = we_cycles;
        m_req(64'h3000, SIZ_DWORD, 1, 0, 64'hAABB_CCDD_EEFF_0011);
        s_beats(4, 1, -1, 64'h0);
        m_idle();
        check("write_we_cycles", 64'(we_cycles - we_before), 64'd8);
        tick();

        // Misaligned 4B at 0x1002: flagged, no strobe, counter untouched.
        m_req(64'h1002, SIZ_WORD, 0, 0, 64'h0);
        bus16.SAckI = 1'b1;
        @(negedge clk);
        check("align_err", 64'(bus16.MErrAlignO), 64'd1);
        check("align_stb", 64'(bus16.SStbO), 64'd0);
        check("align_ack", 64'(bus16.MAckO), 64'd0);
        tick();
        bus16.SAckI = 1'b0;
        @(negedge clk);
        check("align_beat", 64'(bus16.dbgBeat), 64'd0);
        check("align_busy", 64'(bus16.dbgBusy), 64'd0);
        tick();
        m_idle();
        tick();

        // 1B signed read at 0x1003: byte size, signed forwarded, one beat.
        exp_beat(64'h1003, 0, 0, 16'h0);
        exp_resp(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_00A5);
        m_req(64'h1003, SIZ_BYTE, 0, 1, 64'h0);
        @(negedge clk);
        check("byte_ssiz", 64'(bus16.SSizO), 64'd0);
        check("byte_ssigned", 64'(bus16.SSignedO), 64'd1);
        check("byte_align", 64'(bus16.MErrAlignO), 64'd0);
        tick();
        s_beats(1, 0, -1, 64'h0000_0000_0000_00A5);
        m_idle();
        tick();

        // 8B read erroring on beat 2, then a new read restarting at offset 0.
        exp_beat(64'h4000, 0, 0, 16'h0); exp_beat(64'h4002, 0, 0, 16'h0);
        exp_beat(64'h4004, 0, 0, 16'h0);
        exp_resp(1, 64'h0, 64'h0);
        m_req(64'h4000, SIZ_DWORD, 0, 0, 64'h0);
        s_beats(4, 0, 2, 64'h0);
        exp_beat(64'h6000, 0, 0, 16'h0); exp_beat(64'h6002, 0, 0, 16'h0);
        exp_beat(64'h6004, 0, 0, 16'h0); exp_beat(64'h6006, 0, 0, 16'h0);
        exp_resp(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8888_7777_6666_5555);
        m_req(64'h6000, SIZ_DWORD, 0, 0, 64'h0);
        s_beats(4, 0, -1, 64'h8888_7777_6666_5555);
        m_idle();
        tick();

        // Cycle dropped after two beats, then a 4B read at 0x2000.
        exp_beat(64'h7000, 0, 0, 16'h0); exp_beat(64'h7002, 0, 0, 16'h0);
        m_req(64'h7000, SIZ_DWORD, 0, 0, 64'h0);
        s_beats(2, 0, -1, 64'h0000_0000_9999_AAAA);
        m_idle();
        @(negedge clk);
        check("drop_stb", 64'(bus16.SStbO), 64'd0);
        check("drop_ack", 64'(bus16.MAckO), 64'd0);
        tick();
        exp_beat(64'h2000, 0, 0, 16'h0); exp_beat(64'h2002, 0, 0, 16'h0);
        exp_resp(0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_6666_5555);
        m_req(64'h2000, SIZ_WORD, 0, 0, 64'h0);
        s_beats(2, 0, -1, 64'h0000_0000_6666_5555);
        m_idle();
        tick();

        // Back-to-back 4B reads with the request held high.
        exp_beat(64'h8000, 0, 0, 16'h0); exp_beat(64'h8002, 0, 0, 16'h0);
        exp_resp(0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_BEEF_1234);
        exp_beat(64'h8000, 0, 0, 16'h0); exp_beat(64'h8002, 0, 0, 16'h0);
        exp_resp(0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_CAFE_5678);
        m_req(64'h8000, SIZ_WORD, 0, 0, 64'h0);
        s_beats(2, 0, -1, 64'h0000_0000_BEEF_1234);
        s_beats(2, 0, -1, 64'h0000_0000_CAFE_5678);
        m_idle();
        tick();

        // 32-bit slave: 8B read takes two beats.
        bus32.MAdrI = 64'h100; bus32.MSizI = SIZ_DWORD; bus32.MCycI = 1; bus32.MStbI = 1;
        for (int k = 0; k < 2; k++) begin
            bus32.SAckI = 1'b1;
            bus32.SDatI = (k == 0) ? 32'h1111_1111 : 32'h2222_2222;
            @(negedge clk);
            check("u32_adr", bus32.SAdrO, 64'h100 + 64'(4 * k));
            check("u32_ack", 64'(bus32.MAckO), 64'(k == 1));
            if (k == 1) check("u32_dat", bus32.MDatO, 64'h2222_2222_1111_1111);
            tick();
        end
        bus32.SAckI = 0; bus32.SDatI = '0; bus32.MCycI = 0; bus32.MStbI = 0;
        tick();

        // 8-bit slave: 8B read takes eight beats.
        bus8.MAdrI = 64'h200; bus8.MSizI = SIZ_DWORD; bus8.MCycI = 1; bus8.MStbI = 1;
        for (int k = 0; k < 8; k++) begin
            bus8.SAckI = 1'b1;
            bus8.SDatI = 8'(8'h10 + k);
            @(negedge clk);
            check("u8_adr", bus8.SAdrO, 64'h200 + 64'(k));
            check("u8_ack", 64'(bus8.MAckO), 64'(k == 7));
            if (k == 7) check("u8_dat", bus8.MDatO, 64'h1716_1514_1312_1110);
            tick();
        end
        bus8.SAckI = 0; bus8.SDatI = '0;
        bus8.MCycI = 0; bus8.MStbI = 0;
        tick();

        // 8-bit slave: reset pulsed after three beats of a new burst.
        u8_snap = u8_resp;
        bus8.MAdrI = 64'h300; bus8.MCycI = 1; bus8.MStbI = 1;
        for (int k = 0; k < 3; k++) begin
            bus8.SAckI = 1'b1;
            bus8.SDatI = 8'(8'h20 + k);
            tick();
        end
        bus8.SAckI = 1'b0;
        check("abort_mid_beat", 64'(bus8.dbgBeat), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_rst_stb", 64'(bus8.SStbO), 64'd0);
        check("abort_rst_beat", 64'(bus8.dbgBeat), 64'd0);
        bus8.SAckI = 1'b1;
        #1;
        check("abort_rst_ack", 64'(bus8.MAckO), 64'd0);
        bus8.SAckI = 0; bus8.SDatI = '0; bus8.MCycI = 0; bus8.MStbI = 0;
        bus8.MAdrI = '0; bus8.MSizI = 2'd0;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        idle_checks_all("post_rst");
        tick(); tick();
        check("abort_no_resp", 64'(u8_resp - u8_snap), 64'd0);

        check("beat_q_empty", 64'(exp_beat_q.size()), 64'd0);
        check("resp_q_empty", 64'(exp_resp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
